// File: rtl/rolling_sum_if.sv
// Purpose: control/status bundle between the rolling-sum sequencer and its
//          environment (run controls, detector flag, sum controls, status).
// Ports (signals):
//   en, sum_len_sel, trig, holdoff_len, max_hold          -> into the sequencer
//   sum_clr, acc_en, sum_valid, sum_len_sel_q, holding,
//   relearn_cnt, state                                     <- from the sequencer
// Modports: master = environment side, slave = sequencer side.
interface rolling_sum_if #(
   parameter int unsigned SHIFTBITS = 3,
   parameter int unsigned HOLDBITS  = 16,
   parameter int unsigned CNTBITS   = 16
);
   logic                 en;
   logic [SHIFTBITS-1:0] sum_len_sel;
   logic                 trig;
   logic [HOLDBITS-1:0]  holdoff_len;
   logic [HOLDBITS-1:0]  max_hold;
   logic                 sum_clr;
   logic                 acc_en;
   logic                 sum_valid;
   logic [SHIFTBITS-1:0] sum_len_sel_q;
   logic                 holding;
   logic [CNTBITS-1:0]   relearn_cnt;
   logic [2:0]           state;

   modport master (
      output en, sum_len_sel, trig, holdoff_len, max_hold,
      input  sum_clr, acc_en, sum_valid, sum_len_sel_q, holding, relearn_cnt, state
   );

   modport slave (
      input  en, sum_len_sel, trig, holdoff_len, max_hold,
      output sum_clr, acc_en, sum_valid, sum_len_sel_q, holding, relearn_cnt, state
   );
endinterface

// File: rtl/rolling_sum_ctrl.sv
// Purpose: sequences the rolling baseline sum of one ADC channel:
//          IDLE -> CLEAR -> FILL (2^sel samples) -> RUN, freezing the baseline
//          in HOLD while the deviation detector trips and re-learning after a
//          stuck HOLD.
// Ports:
//   clk   - sample clock, one ADC sample per cycle
//   rst_n - asynchronous active-low reset
//   bus   - rolling_sum_if.slave: run controls and detector flag in,
//           sum clear/admit, valid, latched window, hold status,
//           relearn count and state code out
module rolling_sum_ctrl #(
   parameter int unsigned SHIFTBITS = 3,
   parameter int unsigned HOLDBITS  = 16,
   parameter int unsigned CNTBITS   = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   rolling_sum_if.slave  bus
);

   localparam int unsigned FILL_W = 2 ** SHIFTBITS;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FILL  = 3'd2,
      S_RUN   = 3'd3,
      S_HOLD  = 3'd4
   } state_e;

   state_e               state_q, state_d;
   logic [FILL_W-1:0]    fill_ctr_q, fill_ctr_d;
   logic [FILL_W-1:0]    fill_last;
   logic [HOLDBITS-1:0]  hold_ctr_q, hold_ctr_d;
   logic [HOLDBITS-1:0]  hold_age_q, hold_age_d;
   logic [SHIFTBITS-1:0] sel_q, sel_d;
   logic [CNTBITS-1:0]   relearn_q, relearn_d;
   logic                 in_window_state;
   logic                 hold_timeout;

   // Last fill index: 2^sel_q - 1 as a low-ones mask
   assign fill_last = ~({FILL_W{1'b1}} << sel_q);

   assign in_window_state = (state_q == S_FILL) || (state_q == S_RUN) || (state_q == S_HOLD);
   assign hold_timeout    = (bus.max_hold != '0) && (hold_age_q == (bus.max_hold - HOLDBITS'(1)));

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         fill_ctr_q <= '0;
         hold_ctr_q <= '0;
         hold_age_q <= '0;
         sel_q      <= '0;
         relearn_q  <= '0;
      end else begin
         state_q    <= state_d;
         fill_ctr_q <= fill_ctr_d;
         hold_ctr_q <= hold_ctr_d;
         hold_age_q <= hold_age_d;
         sel_q      <= sel_d;
         relearn_q  <= relearn_d;
      end
   end

   // Next-state and counter update; en and window changes override everything
   always_comb begin
      state_d    = state_q;
      fill_ctr_d = fill_ctr_q;
      hold_ctr_d = hold_ctr_q;
      hold_age_d = hold_age_q;
      sel_d      = sel_q;
      relearn_d  = relearn_q;

      if ((state_q != S_IDLE) && !bus.en) begin
         state_d = S_IDLE;
      end else if (in_window_state && (bus.sum_len_sel != sel_q)) begin
         state_d = S_CLEAR;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.en) state_d = S_CLEAR;
            end
            S_CLEAR: begin
               sel_d      = bus.sum_len_sel;
               fill_ctr_d = '0;
               state_d    = S_FILL;
            end
            S_FILL: begin
               fill_ctr_d = fill_ctr_q + FILL_W'(1);
               if (fill_ctr_q == fill_last) state_d = S_RUN;
            end
            S_RUN: begin
               if (bus.trig) begin
                  state_d    = S_HOLD;
                  hold_ctr_d = bus.holdoff_len;
                  hold_age_d = '0;
               end
            end
            S_HOLD: begin
               // Age counts every HOLD cycle regardless of trig, saturating
               if (hold_age_q != '1) hold_age_d = hold_age_q + HOLDBITS'(1);
               if (hold_timeout) begin
                  state_d = S_CLEAR;
                  if (relearn_q != '1) relearn_d = relearn_q + CNTBITS'(1);
               end else if (bus.trig) begin
                  hold_ctr_d = bus.holdoff_len;
               end else if (hold_ctr_q == '0) begin
                  state_d = S_RUN;
               end else begin
                  hold_ctr_d = hold_ctr_q - HOLDBITS'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Moore decodes of the state register; acc_en also gates on live trig in RUN
   assign bus.sum_clr       = (state_q == S_CLEAR);
   assign bus.sum_valid     = (state_q == S_RUN) || (state_q == S_HOLD);
   assign bus.holding       = (state_q == S_HOLD);
   assign bus.acc_en        = (state_q == S_FILL) || ((state_q == S_RUN) && !bus.trig);
   assign bus.sum_len_sel_q = sel_q;
   assign bus.relearn_cnt   = relearn_q;
   assign bus.state         = state_q;

endmodule
